// File: rtl/dpi_pkt_sequencer.sv
// Packet front-end for the regex matcher bank: tracks seen stream IDs, sequences
// load_state / gap / chars / drain / eop, and supplies each packet's category enables.
module dpi_pkt_sequencer #(
  parameter int unsigned NUM_CAT   = 8,
  parameter int unsigned LOAD_GAP  = 2,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [5:0]         in_sid,
  input  logic               cfg_we,
  input  logic [5:0]         cfg_sid,
  input  logic [NUM_CAT-1:0] cfg_mask,
  input  logic               cfg_clr_seen,
  output logic               load_state,
  output logic               new_stream_id,
  output logic [5:0]         stream_id,
  output logic [7:0]         char_in,
  output logic               char_in_vld,
  output logic               eop,
  output logic [NUM_CAT-1:0] enable,
  output logic [15:0]        pkt_count,
  output logic [15:0]        err_count,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_STREAM,
    S_DRAIN,
    S_EOP
  } state_t;

  // in_ready is registered, so the accept that yields the first char happens in the
  // last gap cycle on the matcher side: GAP holds LOAD_GAP-1 cycles, DRAIN holds
  // DRAIN_CYC+1 (the cycle showing the last char plus the flush cycles).
  localparam logic [7:0] GAP_LD   = (LOAD_GAP > 1) ? 8'(LOAD_GAP - 2) : 8'd0;
  localparam logic [7:0] DRAIN_LD = 8'(DRAIN_CYC);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               first_q;
  logic               in_ready_q;
  logic [63:0]        seen_q;
  logic [NUM_CAT-1:0] tbl [64];

  logic               latch, idle_drop, stream_acc, mid_sop;
  logic               load_d, rdy_d, busy_d, eop_d, vld_d, new_d;
  logic [7:0]         char_d;
  logic [5:0]         sid_d;
  logic [NUM_CAT-1:0] en_d;
  logic [15:0]        pkt_d, err_d;

  // The sop beat is only peeked in IDLE; stray non-sop beats are swallowed there.
  assign in_ready   = (state_q == S_IDLE) ? (rst_n && in_valid && !in_sop) : in_ready_q;
  assign latch      = (state_q == S_IDLE) && in_valid && in_sop;
  assign idle_drop  = (state_q == S_IDLE) && in_valid && !in_sop;
  assign stream_acc = (state_q == S_STREAM) && in_valid && in_ready_q;
  assign mid_sop    = stream_acc && in_sop && !first_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch)
        first_q <= 1'b1;
      else if (stream_acc)
        first_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   if (in_valid && in_sop) state_d = S_LOAD;
      S_LOAD: begin
        if (LOAD_GAP > 1) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_STREAM;
        else             cnt_d   = cnt_q - 8'd1;
      end
      S_STREAM: begin
        if (stream_acc && in_eop) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LD;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_EOP;
        else             cnt_d   = cnt_q - 8'd1;
      end
      S_EOP:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_d = (state_d == S_LOAD);
    rdy_d  = (state_d == S_STREAM);
    busy_d = (state_d != S_IDLE);
    eop_d  = (state_d == S_EOP);
    vld_d  = stream_acc;
    char_d = stream_acc ? in_data : char_in;
    new_d  = latch && !seen_q[in_sid];
    sid_d  = latch ? in_sid : (busy_d ? stream_id : '0);
    en_d   = latch ? tbl[in_sid] : (busy_d ? enable : '0);
    pkt_d  = eop_d ? pkt_count + 16'd1 : pkt_count;
    err_d  = err_count;
    if ((idle_drop || mid_sop) && (err_count != '1))
      err_d = err_count + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_q    <= 1'b0;
      load_state    <= 1'b0;
      new_stream_id <= 1'b0;
      stream_id     <= '0;
      char_in       <= '0;
      char_in_vld   <= 1'b0;
      eop           <= 1'b0;
      enable        <= '0;
      pkt_count     <= '0;
      err_count     <= '0;
      busy          <= 1'b0;
    end else begin
      in_ready_q    <= rdy_d;
      load_state    <= load_d;
      new_stream_id <= new_d;
      stream_id     <= sid_d;
      char_in       <= char_d;
      char_in_vld   <= vld_d;
      eop           <= eop_d;
      enable        <= en_d;
      pkt_count     <= pkt_d;
      err_count     <= err_d;
      busy          <= busy_d;
    end
  end

  // The EOP set is ordered after the bulk clear so a coincident clear loses for this sid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q <= '0;
    end else begin
      if (cfg_clr_seen)
        seen_q <= '0;
      if (state_q == S_EOP)
        seen_q[stream_id] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 64; i++)
        tbl[i] <= '0;
    end else if (cfg_we) begin
      tbl[cfg_sid] <= cfg_mask;
    end
  end

endmodule

// File: tb/tb_dpi_pkt_sequencer.sv
// Directed bench for dpi_pkt_sequencer: timestamp-based packet model checked every
// cycle, plus literal pins on hand-computed cycle offsets from each sop presentation.
module tb_dpi_pkt_sequencer;

  localparam int NUM_CAT   = 8;
  localparam int LOAD_GAP  = 2;
  localparam int DRAIN_CYC = 4;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               in_sop;
  logic               in_eop;
  logic [5:0]         in_sid;
  logic               cfg_we;
  logic [5:0]         cfg_sid;
  logic [NUM_CAT-1:0] cfg_mask;
  logic               cfg_clr_seen;
  logic               load_state;
  logic               new_stream_id;
  logic [5:0]         stream_id;
  logic [7:0]         char_in;
  logic               char_in_vld;
  logic               eop;
  logic [NUM_CAT-1:0] enable;
  logic [15:0]        pkt_count;
  logic [15:0]        err_count;
  logic               busy;

  dpi_pkt_sequencer #(
    .NUM_CAT  (NUM_CAT),
    .LOAD_GAP (LOAD_GAP),
    .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_sop       (in_sop),
    .in_eop       (in_eop),
    .in_sid       (in_sid),
    .cfg_we       (cfg_we),
    .cfg_sid      (cfg_sid),
    .cfg_mask     (cfg_mask),
    .cfg_clr_seen (cfg_clr_seen),
    .load_state   (load_state),
    .new_stream_id(new_stream_id),
    .stream_id    (stream_id),
    .char_in      (char_in),
    .char_in_vld  (char_in_vld),
    .eop          (eop),
    .enable       (enable),
    .pkt_count    (pkt_count),
    .err_count    (err_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s cyc=%0d got=timeout expected=completion", nm, cyc);
  endtask

  // Packet model: a packet is a set of timestamps derived from the sop cycle.
  bit          m_ok = 1'b0;
  bit          m_busy, m_closed, m_first, m_new, m_vld;
  int          m_tload, m_topen, m_teop;
  logic [5:0]  m_sid;
  logic [7:0]  m_mask, m_char;
  logic [15:0] m_pkt, m_err;
  bit          m_seen [64];
  logic [7:0]  m_tbl  [64];

  always @(negedge clk) begin
    logic exp_rdy;
    bit   acc;
    int   c;
    c = cyc;
    if (m_busy) exp_rdy = (c >= m_topen) && !m_closed;
    else        exp_rdy = rst_n && in_valid && !in_sop;
    if (m_ok) begin
      chk("in_ready",      32'(in_ready),      32'(exp_rdy));
      chk("load_state",    32'(load_state),    32'(m_busy && c == m_tload));
      chk("new_stream_id", 32'(new_stream_id), 32'(m_busy && c == m_tload && m_new));
      chk("stream_id",     32'(stream_id),     32'(m_busy ? m_sid : 6'd0));
      chk("enable",        32'(enable),        32'(m_busy ? m_mask : 8'd0));
      chk("busy",          32'(busy),          32'(m_busy));
      chk("eop",           32'(eop),           32'(m_busy && c == m_teop));
      chk("char_in_vld",   32'(char_in_vld),   32'(m_vld));
      if (m_vld) chk("char_in", 32'(char_in), 32'(m_char));
      chk("pkt_count",     32'(pkt_count),     32'(m_pkt));
      chk("err_count",     32'(err_count),     32'(m_err));
    end
    if (!rst_n) begin
      m_ok = 1'b1; m_busy = 1'b0; m_vld = 1'b0; m_closed = 1'b0;
      m_pkt = '0; m_err = '0;
      for (int i = 0; i < 64; i++) begin m_seen[i] = 1'b0; m_tbl[i] = '0; end
    end else begin
      acc   = in_valid && exp_rdy;
      m_vld = m_busy && acc;
      if (m_vld) m_char = in_data;
      if (!m_busy) begin
        if (in_valid && in_sop) begin
          m_busy = 1'b1; m_closed = 1'b0; m_first = 1'b1;
          m_sid = in_sid; m_mask = m_tbl[in_sid]; m_new = !m_seen[in_sid];
          m_tload = c + 1; m_topen = c + 1 + LOAD_GAP; m_teop = -1;
        end else if (in_valid && m_err != 16'hFFFF) begin
          m_err = m_err + 16'd1;
        end
      end else begin
        if (acc) begin
          if (in_sop && !m_first && m_err != 16'hFFFF) m_err = m_err + 16'd1;
          m_first = 1'b0;
          if (in_eop) begin m_closed = 1'b1; m_teop = c + DRAIN_CYC + 2; end
        end
        if (c + 1 == m_teop) m_pkt = m_pkt + 16'd1;
      end
      if (cfg_clr_seen) for (int i = 0; i < 64; i++) m_seen[i] = 1'b0;
      if (m_busy && c == m_teop) begin m_seen[m_sid] = 1'b1; m_busy = 1'b0; end
      if (cfg_we) m_tbl[cfg_sid] = cfg_mask;
    end
  end

  // Literal pin: value of one DUT output at an absolute cycle.
  task automatic pin(input string nm, input int at, input int sel, input logic [31:0] exp);
    logic [31:0] v;
    while (cyc < at) @(negedge clk);
    if (cyc != at) begin timeout(nm); return; end
    case (sel)
      0: v = 32'(load_state);
      1: v = 32'(new_stream_id);
      2: v = 32'(stream_id);
      3: v = 32'(enable);
      4: v = 32'(char_in_vld);
      5: v = 32'(eop);
      6: v = 32'(pkt_count);
      7: v = 32'(err_count);
      8: v = 32'(char_in);
      default: v = 32'(busy);
    endcase
    chk(nm, v, exp);
  endtask

  task automatic wait_idle();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (busy !== 1'b0 && g < 60);
    if (busy !== 1'b0) timeout("wait_idle");
    @(posedge clk); #1;
  endtask

  task automatic cfg_wr(input logic [5:0] sid, input logic [7:0] m);
    cfg_we = 1'b1; cfg_sid = sid; cfg_mask = m;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Bytes are 'a','b',...; extra_sop marks a mid-packet sop index; abort_after pulses reset.
  task automatic send_pkt(input logic [5:0] sid, input int n, input bit bub, input int extra_sop,
                          input bit cfg_now, input logic [7:0] cfg_m, input int abort_after);
    bit acc;
    int g;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h61 + i); in_sid = sid;
      in_sop = (i == 0) || (i == extra_sop); in_eop = (i == n - 1);
      if (i == 0 && cfg_now) begin cfg_we = 1'b1; cfg_sid = sid; cfg_mask = cfg_m; end
      g = 0;
      forever begin
        @(negedge clk);
        acc = (in_ready === 1'b1);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (acc) break;
        g++;
        if (g > 100) break;
      end
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      if (!acc) begin timeout("handshake"); break; end
      if (i == abort_after) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        break;
      end
      if (bub && i < n - 1) begin @(posedge clk); #1; end
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=stuck expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0; in_sid = '0;
    cfg_we = 1'b0; cfg_sid = '0; cfg_mask = '0; cfg_clr_seen = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset pkt_count", 32'(pkt_count), 32'd0);
    @(posedge clk); #1;
    cfg_wr(6'd5, 8'h01);

    // 3-byte packet on unseen sid 5
    c0 = cyc;
    fork
      send_pkt(6'd5, 3, 1'b0, -1, 1'b0, 8'h00, -1);
      begin
        pin("t1 load",      c0 + 1,  0, 1);
        pin("t1 new",       c0 + 1,  1, 1);
        pin("t1 sid",       c0 + 1,  2, 5);
        pin("t1 enable",    c0 + 1,  3, 8'h01);
        pin("t1 vld_pre",   c0 + 3,  4, 0);
        pin("t1 vld_first", c0 + 4,  4, 1);
        pin("t1 char_a",    c0 + 4,  8, 8'h61);
        pin("t1 vld_last",  c0 + 6,  4, 1);
        pin("t1 vld_post",  c0 + 7,  4, 0);
        pin("t1 eop_pre",   c0 + 10, 5, 0);
        pin("t1 eop",       c0 + 11, 5, 1);
        pin("t1 pkt",       c0 + 11, 6, 1);
      end
    join

    // seen tracking and clear
    c0 = cyc;
    fork
      send_pkt(6'd5, 2, 1'b0, -1, 1'b0, 8'h00, -1);
      pin("t2 new_seen", c0 + 1, 1, 0);
    join
    cfg_clr_seen = 1'b1;
    @(posedge clk); #1;
    cfg_clr_seen = 1'b0;
    c0 = cyc;
    fork
      send_pkt(6'd5, 1, 1'b0, -1, 1'b0, 8'h00, -1);
      begin
        pin("t2 new_clr",  c0 + 1, 1, 1);
        pin("t2 one_vld",  c0 + 4, 4, 1);
        pin("t2 one_eop",  c0 + 9, 5, 1);
      end
    join

    // bubbles every other cycle on a 4-byte packet
    c0 = cyc;
    fork
      send_pkt(6'd9, 4, 1'b1, -1, 1'b0, 8'h00, -1);
      begin
        pin("t3 enable0",  c0 + 1,  3, 0);
        pin("t3 vld0",     c0 + 4,  4, 1);
        pin("t3 gap",      c0 + 5,  4, 0);
        pin("t3 vld1",     c0 + 6,  4, 1);
        pin("t3 char_d",   c0 + 10, 8, 8'h64);
        pin("t3 drain",    c0 + 14, 5, 0);
        pin("t3 eop",      c0 + 15, 5, 1);
      end
    join

    // protocol errors: stray beat in IDLE, then a mid-packet sop
    in_valid = 1'b1; in_sop = 1'b0; in_data = 8'h7A; in_sid = 6'd3;
    @(negedge clk);
    chk("t4 drop ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4 drop err", 32'(err_count), 32'd1);
    chk("t4 no load", 32'(load_state), 32'd0);
    @(posedge clk); #1;
    send_pkt(6'd12, 4, 1'b0, 2, 1'b0, 8'h00, -1);
    @(negedge clk);
    chk("t4 mid err", 32'(err_count), 32'd2);
    chk("t4 pkt", 32'(pkt_count), 32'd5);
    @(posedge clk); #1;

    // table write colliding with the sop latch
    c0 = cyc;
    fork
      send_pkt(6'd7, 2, 1'b0, -1, 1'b1, 8'hFF, -1);
      pin("t5 en_old", c0 + 1, 3, 8'h00);
    join
    c0 = cyc;
    fork
      send_pkt(6'd7, 1, 1'b0, -1, 1'b0, 8'h00, -1);
      pin("t5 en_new", c0 + 1, 3, 8'hFF);
    join

    // reset in the middle of STREAM
    c0 = cyc;
    fork
      send_pkt(6'd5, 4, 1'b0, -1, 1'b0, 8'h00, 1);
      begin
        pin("t6 busy",   c0 + 6, 9, 0);
        pin("t6 vld",    c0 + 6, 4, 0);
        pin("t6 pkt",    c0 + 6, 6, 0);
        pin("t6 err",    c0 + 6, 7, 0);
        pin("t6 sid",    c0 + 6, 2, 0);
      end
    join
    c0 = cyc;
    fork
      send_pkt(6'd5, 2, 1'b0, -1, 1'b0, 8'h00, -1);
      begin
        pin("t6 reload", c0 + 1, 0, 1);
        pin("t6 new",    c0 + 1, 1, 1);
        pin("t6 en",     c0 + 1, 3, 0);
        pin("t6 eop",    c0 + 10, 5, 1);
        pin("t6 pkt1",   c0 + 10, 6, 1);
      end
    join

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
